// File: rtl/vga_rect_filler.sv
// rtl/vga_rect_filler.sv - raster-order solid rectangle filler driving a pixel write port
// Clips to the drawable area and streams one pixel per accepted plot/plot_ready handshake.
module vga_rect_filler #(
  parameter string RESOLUTION              = "320x240",
  parameter int    BITS_PER_COLOUR_CHANNEL = 4,
  localparam int   XW = (RESOLUTION == "160x120") ? 8 : 9,
  localparam int   YW = (RESOLUTION == "160x120") ? 7 : 8,
  localparam int   CW = 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  input  logic [CW-1:0] colour,
  input  logic          plot_ready,
  output logic          plot,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour_out,
  output logic          busy,
  output logic          done
);

  localparam int MAX_X_I = (RESOLUTION == "160x120") ? 160 : 320;
  localparam int MAX_Y_I = (RESOLUTION == "160x120") ? 120 : 240;
  localparam logic [XW:0]   MAX_X  = (XW + 1)'(MAX_X_I);
  localparam logic [YW:0]   MAX_Y  = (YW + 1)'(MAX_Y_I);
  localparam logic [XW-1:0] X_LAST = XW'(MAX_X_I - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MAX_Y_I - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state, state_n;
  logic [XW-1:0] x_left, x_left_n, x_end, x_end_n, x_n;
  logic [YW-1:0] y_end, y_end_n, y_n;
  logic [CW-1:0] colour_n;
  logic          plot_n, busy_n, done_n;

  // Edge sums are one bit wider than the coordinates so x0+width cannot wrap.
  logic [XW:0] x_sum;
  logic [YW:0] y_sum;
  logic        degenerate;

  always_comb begin
    x_sum      = {1'b0, x0} + {1'b0, width};
    y_sum      = {1'b0, y0} + {1'b0, height};
    degenerate = (width == '0) || (height == '0) ||
                 ({1'b0, x0} >= MAX_X) || ({1'b0, y0} >= MAX_Y);
  end

  always_comb begin
    state_n  = state;
    x_left_n = x_left;
    x_end_n  = x_end;
    y_end_n  = y_end;
    x_n      = x;
    y_n      = y;
    colour_n = colour_out;
    plot_n   = plot;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          busy_n   = 1'b1;
          x_left_n = x0;
          x_end_n  = (x_sum > MAX_X) ? X_LAST : x0 + width - 1'b1;
          y_end_n  = (y_sum > MAX_Y) ? Y_LAST : y0 + height - 1'b1;
          if (degenerate) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n  = FILL;
            plot_n   = 1'b1;
            x_n      = x0;
            y_n      = y0;
            colour_n = colour;
          end
        end
      end
      FILL: begin
        if (plot && plot_ready) begin
          if (x != x_end) begin
            x_n = x + 1'b1;
          end else if (y != y_end) begin
            x_n = x_left;
            y_n = y + 1'b1;
          end else begin
            plot_n  = 1'b0;
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        plot_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      x_left     <= '0;
      x_end      <= '0;
      y_end      <= '0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      x_left     <= x_left_n;
      x_end      <= x_end_n;
      y_end      <= y_end_n;
      x          <= x_n;
      y          <= y_n;
      colour_out <= colour_n;
      plot       <= plot_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule
